// File: rtl/fetch_entry_buffer.sv
// fetch_entry_buffer: in-order decoupling FIFO between frontend and ID stage that
// closes its input after enqueueing a faulting fetch, until the next flush.
package fetch_entry_buffer_pkg;
    typedef struct packed {
        logic [31:0] xlen;
    } cfg_t;
    localparam cfg_t cva6_cfg_empty = '0;
    typedef struct packed {
        logic [31:0] cause;
        logic [31:0] tval;
        logic        valid;
    } exception_t;
    typedef struct packed {
        logic [31:0] address;
        logic [31:0] instruction;
        exception_t  ex;
    } fetch_entry_t;
endpackage

module fetch_entry_buffer #(
    parameter fetch_entry_buffer_pkg::cfg_t CVA6Cfg = fetch_entry_buffer_pkg::cva6_cfg_empty,
    parameter type fetch_entry_t = fetch_entry_buffer_pkg::fetch_entry_t,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     flush_i,
    input  fetch_entry_t             fetch_entry_i,
    input  logic                     fetch_entry_valid_i,
    output logic                     fetch_entry_ready_o,
    output fetch_entry_t             fetch_entry_o,
    output logic                     fetch_entry_valid_o,
    input  logic                     fetch_entry_ready_i,
    output logic [$clog2(DEPTH):0]   usage_o,
    output logic                     ex_blocked_o
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    fetch_entry_t      mem [DEPTH];
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic [PW:0]       count;
    logic              ex_blocked_q;
    logic              push, pop;

    // Handshake outputs depend only on registered state.
    assign fetch_entry_ready_o = (count != FULL_CNT) && !ex_blocked_q;
    assign fetch_entry_valid_o = (count != '0);
    assign fetch_entry_o       = mem[rd_ptr];
    assign usage_o             = count;
    assign ex_blocked_o        = ex_blocked_q;

    assign push = fetch_entry_valid_i && fetch_entry_ready_o && !flush_i;
    assign pop  = fetch_entry_valid_o && fetch_entry_ready_i && !flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            ex_blocked_q <= 1'b0;
        end else if (flush_i) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            ex_blocked_q <= 1'b0;
        end else begin
            wr_ptr       <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr       <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count        <= count + (PW+1)'(push) - (PW+1)'(pop);
            ex_blocked_q <= ex_blocked_q || (push && fetch_entry_i.ex.valid);
        end
    end

    // Storage is never cleared; validity is tracked by count alone.
    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= fetch_entry_i;
    end
endmodule
